// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage with delay-slot redirect, halt and fault handling
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter int unsigned ROM_BYTES    = 3000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_rdata,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    input  logic        id_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        active,
    output logic        fetch_fault
);

    typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} state_t;

    // Highest word address that still lies inside the ROM window.
    localparam logic [31:0] ROM_LAST = RESET_VECTOR + 32'(ROM_BYTES) - 32'd4;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic        pc_bad;
    logic        can_take;
    logic        redirect_take;
    logic        halt_take;
    logic        fault_take;
    logic        capture;

    assign instr_addr = pc;
    assign pc_bad     = (pc[1:0] != 2'b00) || (pc < RESET_VECTOR) || (pc > ROM_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture/redirect/halt/fault decisions and next state; a redirect to 0
    // wins over the range check so the delay slot is always delivered.
    always_comb begin
        state_next    = state;
        can_take      = (state == RUN) && (!id_valid || id_ready);
        redirect_take = (state == RUN) && id_valid && id_ready && redirect_valid;
        halt_take     = redirect_take && (redirect_target == 32'd0);
        fault_take    = can_take && pc_bad && !halt_take;
        capture       = can_take && !fault_take;
        case (state)
            IDLE:    state_next = RUN;
            RUN: begin
                if (halt_take) begin
                    state_next = HALT;
                end else if (fault_take) begin
                    state_next = FAULT;
                end
            end
            default: state_next = state;
        endcase
    end

    // PC, decode output registers and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_VECTOR;
            id_valid    <= 1'b0;
            id_instr    <= 32'd0;
            id_pc       <= 32'd0;
            active      <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            active <= (state_next == RUN);
            if (fault_take) begin
                fetch_fault <= 1'b1;
            end
            if (capture) begin
                id_instr <= instr_rdata;
                id_pc    <= pc;
                id_valid <= 1'b1;
                pc       <= redirect_take ? redirect_target : pc + 32'd4;
            end else if (id_ready) begin
                id_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] RV   = 32'hBFC00000;
    localparam logic [31:0] LAST = 32'hBFC00BB4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr_addr;
    logic [31:0] instr_rdata;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic        id_ready = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_target = 32'd0;
    logic        active;
    logic        fetch_fault;

    int pass_cnt = 0;
    int total_cnt = 0;

    fetch_unit #(.RESET_VECTOR(RV), .ROM_BYTES(3000)) dut (
        .clk(clk), .rst_n(rst_n), .instr_addr(instr_addr), .instr_rdata(instr_rdata),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .active(active), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hA5C30F1E;
    endfunction

    assign instr_rdata = rom(instr_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        id_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_target = 32'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic step(input logic rdy, input logic rv, input logic [31:0] tgt);
        id_ready = rdy;
        redirect_valid = rv;
        redirect_target = tgt;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        rdy;
        logic        rv;
        logic [31:0] tgt;
        logic        e_valid;
        logic        chk_pc;
        logic [31:0] e_pc;
        logic [31:0] e_addr;
        logic        e_active;
    } vec_t;

    vec_t vecs[14];

    logic [31:0] exp_next;
    logic [31:0] ptgt;
    logic [31:0] nxt;
    logic [31:0] tgt_r;
    logic        pend;
    logic        rdy_r;
    logic        rv_r;
    int          accepts;

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 32'd0,        1'b0, 1'b0, 32'd0,        RV,            1'b1};
        vecs[1]  = '{1'b1, 1'b0, 32'd0,        1'b1, 1'b1, RV,           RV + 32'h4,    1'b1};
        vecs[2]  = '{1'b1, 1'b0, 32'd0,        1'b1, 1'b1, RV + 32'h4,   RV + 32'h8,    1'b1};
        vecs[3]  = '{1'b1, 1'b0, 32'd0,        1'b1, 1'b1, RV + 32'h8,   RV + 32'hC,    1'b1};
        vecs[4]  = '{1'b1, 1'b1, RV + 32'h100, 1'b1, 1'b1, RV + 32'hC,   RV + 32'h100,  1'b1};
        vecs[5]  = '{1'b1, 1'b0, 32'd0,        1'b1, 1'b1, RV + 32'h100, RV + 32'h104,  1'b1};
        vecs[6]  = '{1'b0, 1'b1, RV + 32'h200, 1'b1, 1'b1, RV + 32'h100, RV + 32'h104,  1'b1};
        vecs[7]  = '{1'b0, 1'b1, 32'd0,        1'b1, 1'b1, RV + 32'h100, RV + 32'h104,  1'b1};
        vecs[8]  = '{1'b1, 1'b0, 32'd0,        1'b1, 1'b1, RV + 32'h104, RV + 32'h108,  1'b1};
        vecs[9]  = '{1'b1, 1'b0, 32'd0,        1'b1, 1'b1, RV + 32'h108, RV + 32'h10C,  1'b1};
        vecs[10] = '{1'b1, 1'b1, 32'd0,        1'b1, 1'b1, RV + 32'h10C, 32'd0,         1'b0};
        vecs[11] = '{1'b0, 1'b0, 32'd0,        1'b1, 1'b1, RV + 32'h10C, 32'd0,         1'b0};
        vecs[12] = '{1'b1, 1'b0, 32'd0,        1'b0, 1'b0, 32'd0,        32'd0,         1'b0};
        vecs[13] = '{1'b1, 1'b1, RV + 32'h40,  1'b0, 1'b0, 32'd0,        32'd0,         1'b0};

        // Reset values and table-driven run: sequential fetch, redirect, stall, halt.
        do_reset();
        chk("rst_valid", {31'd0, id_valid}, 32'd0);
        chk("rst_pc", id_pc, 32'd0);
        chk("rst_instr", id_instr, 32'd0);
        chk("rst_active", {31'd0, active}, 32'd0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        chk("rst_addr", instr_addr, RV);
        for (int i = 0; i < 14; i++) begin
            step(vecs[i].rdy, vecs[i].rv, vecs[i].tgt);
            chk($sformatf("vec%0d_valid", i), {31'd0, id_valid}, {31'd0, vecs[i].e_valid});
            chk($sformatf("vec%0d_addr", i), instr_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d_active", i), {31'd0, active}, {31'd0, vecs[i].e_active});
            chk($sformatf("vec%0d_fault", i), {31'd0, fetch_fault}, 32'd0);
            if (vecs[i].chk_pc) begin
                chk($sformatf("vec%0d_pc", i), id_pc, vecs[i].e_pc);
                chk($sformatf("vec%0d_instr", i), id_instr, rom(vecs[i].e_pc));
            end
        end

        // Stall after first capture, then reset asserted mid-stall.
        do_reset();
        step(1'b1, 1'b0, 32'd0);
        step(1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 32'd0);
            chk("stall_pc", id_pc, RV);
            chk("stall_addr", instr_addr, RV + 32'h4);
        end
        step(1'b1, 1'b0, 32'd0);
        chk("unstall_pc", id_pc, RV + 32'h4);
        step(1'b0, 1'b0, 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, id_valid}, 32'd0);
        chk("midrst_pc", id_pc, 32'd0);
        chk("midrst_instr", id_instr, 32'd0);
        chk("midrst_active", {31'd0, active}, 32'd0);
        chk("midrst_addr", instr_addr, RV);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        chk("postrst_pc", id_pc, RV);
        chk("postrst_valid", {31'd0, id_valid}, 32'd1);

        // Misaligned redirect target: delay slot delivered, then fault.
        do_reset();
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, RV + 32'h102);
        chk("mis_slot_pc", id_pc, RV + 32'h4);
        step(1'b0, 1'b0, 32'd0);
        chk("mis_hold_fault", {31'd0, fetch_fault}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
        chk("mis_active", {31'd0, active}, 32'd0);
        chk("mis_valid", {31'd0, id_valid}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        chk("mis_sticky", {31'd0, fetch_fault}, 32'd1);
        chk("mis_nocap", {31'd0, id_valid}, 32'd0);

        // Last ROM word is fetchable; the word after it faults.
        do_reset();
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, LAST);
        step(1'b1, 1'b0, 32'd0);
        chk("last_pc", id_pc, LAST);
        chk("last_fault", {31'd0, fetch_fault}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        chk("end_fault", {31'd0, fetch_fault}, 32'd1);
        chk("end_valid", {31'd0, id_valid}, 32'd0);
        chk("end_addr", instr_addr, LAST + 32'h4);

        // Redirect to 0 from the last word: halt wins over out-of-range delay slot.
        do_reset();
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, LAST);
        step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'd0);
        chk("hp_pc", id_pc, LAST + 32'h4);
        chk("hp_valid", {31'd0, id_valid}, 32'd1);
        chk("hp_fault", {31'd0, fetch_fault}, 32'd0);
        chk("hp_active", {31'd0, active}, 32'd0);
        step(1'b1, 1'b0, 32'd0);
        chk("hp_drain", {31'd0, id_valid}, 32'd0);
        chk("hp_fault2", {31'd0, fetch_fault}, 32'd0);

        // Randomized run against an instruction-stream model.
        do_reset();
        exp_next = RV;
        pend = 1'b0;
        ptgt = 32'd0;
        accepts = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            chk("rnd_valid", {31'd0, id_valid}, (cyc >= 2) ? 32'd1 : 32'd0);
            if (cyc >= 1) chk("rnd_active", {31'd0, active}, 32'd1);
            if (id_valid) begin
                chk("rnd_pc", id_pc, exp_next);
                chk("rnd_instr", id_instr, rom(exp_next));
                chk("rnd_addr", instr_addr, pend ? ptgt : exp_next + 32'h4);
            end
            rdy_r = ($urandom_range(0, 3) != 0);
            if (id_valid && rdy_r) begin
                accepts++;
                rv_r  = !pend && ($urandom_range(0, 5) == 0);
                tgt_r = rv_r ? RV + 32'(4 * $urandom_range(0, 300)) : $urandom();
                nxt   = pend ? ptgt : exp_next + 32'h4;
                pend  = rv_r;
                ptgt  = tgt_r;
                exp_next = nxt;
            end else begin
                rv_r  = ($urandom_range(0, 1) != 0);
                tgt_r = ($urandom_range(0, 1) != 0) ? 32'd0 : $urandom();
            end
            step(rdy_r, rv_r, tgt_r);
        end
        chk("rnd_fault", {31'd0, fetch_fault}, 32'd0);
        chk("rnd_accepts", (accepts >= 300) ? 32'd1 : 32'd0, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
